// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: PC, instruction register and
// imem req/ack fetch sequencing feeding the control unit.
module instr_fetch_unit #(
   parameter int         ADDR_W  = 4,
   parameter int         INSTR_W = 10,
   parameter logic [3:0] HALT_OP = 4'b1111
) (
   input  logic               clk,
   input  logic               rst,
   output logic               imem_req,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic               imem_ack,
   input  logic [INSTR_W-1:0] imem_rdata,
   input  logic               jmp_sel,
   output logic [3:0]         opcode,
   output logic [2:0]         op_a,
   output logic [2:0]         op_b,
   output logic               instr_valid,
   output logic [ADDR_W-1:0]  pc,
   output logic               halted
);

   typedef enum logic [1:0] {
      ST_RESET = 2'd0,
      ST_FETCH = 2'd1,
      ST_EXEC  = 2'd2,
      ST_HALT  = 2'd3
   } state_t;

   state_t              r_state;
   logic [ADDR_W-1:0]   r_pc;
   logic [INSTR_W-1:0]  r_ir;
   logic                r_req;
   logic                r_valid;
   logic                r_halted;

   logic [3:0]          w_opcode;
   logic                w_is_halt;
   logic [ADDR_W-1:0]   w_pc_inc;
   logic [ADDR_W-1:0]   w_jmp_tgt;

   // IR field decode and next-PC candidates
   assign w_opcode  = r_ir[9:6];
   assign w_is_halt = (w_opcode == HALT_OP);
   assign w_pc_inc  = r_pc + {{(ADDR_W-1){1'b0}}, 1'b1};
   assign w_jmp_tgt = r_ir[ADDR_W-1:0];

   // Fetch/execute sequencer; all outputs come straight from registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= ST_RESET;
         r_pc     <= '0;
         r_ir     <= '0;
         r_req    <= 1'b0;
         r_valid  <= 1'b0;
         r_halted <= 1'b0;
      end else begin
         case (r_state)
            ST_RESET: begin
               r_state <= ST_FETCH;
               r_req   <= 1'b1;
            end
            ST_FETCH: begin
               if (imem_ack) begin
                  r_ir    <= imem_rdata;
                  r_state <= ST_EXEC;
                  r_req   <= 1'b0;
                  r_valid <= 1'b1;
               end
            end
            ST_EXEC: begin
               r_valid <= 1'b0;
               if (w_is_halt) begin
                  // HALT wins over a simultaneous jump request
                  r_state  <= ST_HALT;
                  r_halted <= 1'b1;
               end else begin
                  r_state <= ST_FETCH;
                  r_req   <= 1'b1;
                  r_pc    <= jmp_sel ? w_jmp_tgt : w_pc_inc;
               end
            end
            ST_HALT: begin
               r_state <= ST_HALT;
            end
            default: begin
               r_state <= ST_RESET;
               r_req   <= 1'b0;
               r_valid <= 1'b0;
            end
         endcase
      end
   end

   assign imem_req    = r_req;
   assign imem_addr   = r_pc;
   assign opcode      = w_opcode;
   assign op_a        = r_ir[5:3];
   assign op_b        = r_ir[2:0];
   assign instr_valid = r_valid;
   assign pc          = r_pc;
   assign halted      = r_halted;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit.
// Each task drives one scenario and checks the packed output vector.
module tb_instr_fetch_unit;

   logic       clk = 1'b0;
   logic       rst;
   logic       imem_req;
   logic [3:0] imem_addr;
   logic       imem_ack;
   logic [9:0] imem_rdata;
   logic       jmp_sel;
   logic [3:0] opcode;
   logic [2:0] op_a;
   logic [2:0] op_b;
   logic       instr_valid;
   logic [3:0] pc;
   logic       halted;

   int checks   = 0;
   int failures = 0;

   logic [20:0] obs;
   logic [20:0] e;

   instr_fetch_unit #(
      .ADDR_W  (4),
      .INSTR_W (10),
      .HALT_OP (4'b1111)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .jmp_sel     (jmp_sel),
      .opcode      (opcode),
      .op_a        (op_a),
      .op_b        (op_b),
      .instr_valid (instr_valid),
      .pc          (pc),
      .halted      (halted)
   );

   always #5 clk = ~clk;

   assign obs = {imem_req, imem_addr, instr_valid,
                 opcode, op_a, op_b, pc, halted};

   function automatic logic [20:0] ev(
      input logic       req,
      input logic [3:0] addr,
      input logic       v,
      input logic [3:0] op,
      input logic [2:0] a,
      input logic [2:0] b,
      input logic [3:0] p,
      input logic       h);
      return {req, addr, v, op, a, b, p, h};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; imem_ack = 1'b0;
      imem_rdata = '0; jmp_sel = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      e = '0; checks++;
      if (obs !== e) begin
         failures++;
         $display("FAIL reset_hold obs=%h exp=%h", obs, e);
      end
      rst = 1'b0;
      tick();
      e = ev(1, 0, 0, 0, 0, 0, 0, 0); checks++;
      if (obs !== e) begin
         failures++;
         $display("FAIL first_fetch obs=%h exp=%h", obs, e);
      end
   endtask

   task automatic test_basic();
      imem_ack = 1'b1; imem_rdata = 10'h041;
      tick();
      e = ev(0, 0, 1, 1, 0, 1, 0, 0); checks++;
      if (obs !== e) begin
         failures++;
         $display("FAIL basic_exec0 obs=%h exp=%h", obs, e);
      end
      imem_ack = 1'b0;
      tick();
      e = ev(1, 1, 0, 1, 0, 1, 1, 0); checks++;
      if (obs !== e) begin
         failures++;
         $display("FAIL basic_fetch1 obs=%h exp=%h", obs, e);
      end
      imem_ack = 1'b1; imem_rdata = 10'h082;
      tick();
      e = ev(0, 1, 1, 2, 0, 2, 1, 0); checks++;
      if (obs !== e) begin
         failures++;
         $display("FAIL basic_exec1 obs=%h exp=%h", obs, e);
      end
      imem_ack = 1'b0;
      tick();
      e = ev(1, 2, 0, 2, 0, 2, 2, 0); checks++;
      if (obs !== e) begin
         failures++;
         $display("FAIL basic_fetch2 obs=%h exp=%h", obs, e);
      end
   endtask

   task automatic test_delayed_ack();
      imem_ack = 1'b0; imem_rdata = 10'h3FF;
      for (int i = 0; i < 3; i++) begin
         tick();
         e = ev(1, 2, 0, 2, 0, 2, 2, 0); checks++;
         if (obs !== e) begin
            failures++;
            $display("FAIL wait_%0d obs=%h exp=%h", i, obs, e);
         end
      end
      imem_ack = 1'b1; imem_rdata = 10'h109;
      tick();
      e = ev(0, 2, 1, 4, 1, 1, 2, 0); checks++;
      if (obs !== e) begin
         failures++;
         $display("FAIL late_ack obs=%h exp=%h", obs, e);
      end
      // stray ack during EXEC must not reload IR
      imem_ack = 1'b1; imem_rdata = 10'h3C0; jmp_sel = 1'b1;
      tick();
      imem_ack = 1'b0; jmp_sel = 1'b0;
      e = ev(1, 9, 0, 4, 1, 1, 9, 0); checks++;
      if (obs !== e) begin
         failures++;
         $display("FAIL jump_to9 obs=%h exp=%h", obs, e);
      end
   endtask

   task automatic test_jump_nojump();
      imem_ack = 1'b1; imem_rdata = 10'h109;
      tick();
      e = ev(0, 9, 1, 4, 1, 1, 9, 0); checks++;
      if (obs !== e) begin
         failures++;
         $display("FAIL nj_exec obs=%h exp=%h", obs, e);
      end
      imem_ack = 1'b0; jmp_sel = 1'b0;
      tick();
      e = ev(1, 10, 0, 4, 1, 1, 10, 0); checks++;
      if (obs !== e) begin
         failures++;
         $display("FAIL nojump obs=%h exp=%h", obs, e);
      end
      imem_ack = 1'b1; imem_rdata = 10'h00F;
      tick();
      e = ev(0, 10, 1, 0, 1, 7, 10, 0); checks++;
      if (obs !== e) begin
         failures++;
         $display("FAIL j15_exec obs=%h exp=%h", obs, e);
      end
      imem_ack = 1'b0; jmp_sel = 1'b1;
      tick();
      jmp_sel = 1'b0;
      e = ev(1, 15, 0, 0, 1, 7, 15, 0); checks++;
      if (obs !== e) begin
         failures++;
         $display("FAIL jump_to15 obs=%h exp=%h", obs, e);
      end
   endtask

   task automatic test_wrap();
      // jmp_sel high during FETCH has no effect
      jmp_sel = 1'b1;
      imem_ack = 1'b1; imem_rdata = 10'h082;
      tick();
      jmp_sel = 1'b0;
      e = ev(0, 15, 1, 2, 0, 2, 15, 0); checks++;
      if (obs !== e) begin
         failures++;
         $display("FAIL wrap_exec obs=%h exp=%h", obs, e);
      end
      imem_ack = 1'b0;
      tick();
      e = ev(1, 0, 0, 2, 0, 2, 0, 0); checks++;
      if (obs !== e) begin
         failures++;
         $display("FAIL wrap_fetch obs=%h exp=%h", obs, e);
      end
   endtask

   task automatic test_halt();
      imem_ack = 1'b1; imem_rdata = 10'h3C0;
      tick();
      e = ev(0, 0, 1, 15, 0, 0, 0, 0); checks++;
      if (obs !== e) begin
         failures++;
         $display("FAIL halt_exec obs=%h exp=%h", obs, e);
      end
      imem_ack = 1'b0; jmp_sel = 1'b1;
      tick();
      jmp_sel = 1'b0;
      e = ev(0, 0, 0, 15, 0, 0, 0, 1); checks++;
      if (obs !== e) begin
         failures++;
         $display("FAIL halt_enter obs=%h exp=%h", obs, e);
      end
      for (int i = 0; i < 20; i++) begin
         imem_ack = (i % 3 == 0);
         imem_rdata = 10'h041;
         jmp_sel = (i % 2 == 0);
         tick();
         e = ev(0, 0, 0, 15, 0, 0, 0, 1); checks++;
         if (obs !== e) begin
            failures++;
            $display("FAIL halt_hold_%0d obs=%h exp=%h", i, obs, e);
         end
      end
      imem_ack = 1'b0; jmp_sel = 1'b0;
   endtask

   task automatic test_reset_in_halt();
      rst = 1'b1;
      #1;
      e = '0; checks++;
      if (obs !== e) begin
         failures++;
         $display("FAIL rst_halt obs=%h exp=%h", obs, e);
      end
      tick();
      rst = 1'b0;
      tick();
      e = ev(1, 0, 0, 0, 0, 0, 0, 0); checks++;
      if (obs !== e) begin
         failures++;
         $display("FAIL rst_halt_rel obs=%h exp=%h", obs, e);
      end
   endtask

   task automatic test_reset_mid_fetch();
      imem_ack = 1'b1; imem_rdata = 10'h041;
      tick();
      imem_ack = 1'b0;
      tick();
      e = ev(1, 1, 0, 1, 0, 1, 1, 0); checks++;
      if (obs !== e) begin
         failures++;
         $display("FAIL pre_rst obs=%h exp=%h", obs, e);
      end
      rst = 1'b1;
      #1;
      e = '0; checks++;
      if (obs !== e) begin
         failures++;
         $display("FAIL rst_fetch obs=%h exp=%h", obs, e);
      end
      tick();
      // late ack arriving in RESET state is ignored
      rst = 1'b0; imem_ack = 1'b1; imem_rdata = 10'h082;
      tick();
      imem_ack = 1'b0;
      e = ev(1, 0, 0, 0, 0, 0, 0, 0); checks++;
      if (obs !== e) begin
         failures++;
         $display("FAIL rst_fetch_rel obs=%h exp=%h", obs, e);
      end
   endtask

   initial begin
      rst = 1'b1; imem_ack = 1'b0;
      imem_rdata = '0; jmp_sel = 1'b0;
      test_reset();
      test_basic();
      test_delayed_ack();
      test_jump_nojump();
      test_wrap();
      test_halt();
      test_reset_in_halt();
      test_reset_mid_fetch();
      $display("TB_RESULT checks=%0d failures=%0d",
               checks, failures);
      $finish;
   end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Sequential front end feeding the control unit: holds PC and instruction register, fetches words from instruction memory over a req/ack handshake, and presents opcode plus operand fields for exactly one execute cycle per instruction.
- Consumes the control unit's jump decision (jmp_sel) to redirect the PC.
- Halts on the HALT opcode.

Parameters:
ADDR_W, 4, PC / instruction-memory address width (2..6)
INSTR_W, 10, instruction width: opcode [9:6], op_a [5:3], op_b [2:0]; fixed at 10, other values unsupported
HALT_OP, 4'b1111, opcode that stops fetching

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
imem_req  out  1  fetch request to instruction memory
imem_addr  out  ADDR_W  fetch address (= PC while imem_req=1)
imem_ack  in  1  memory has valid imem_rdata this cycle
imem_rdata  in  INSTR_W  fetched instruction word
jmp_sel  in  1  from control unit; sampled only in EXEC
opcode  out  4  IR[9:6] to control unit
op_a  out  3  IR[5:3]
op_b  out  3  IR[2:0]
instr_valid  out  1  high for exactly one cycle per instruction (EXEC)
pc  out  ADDR_W  current PC
halted  out  1  high in HALT state

Behaviour:
- Reset: async assert forces state=RESET, PC=0, IR=0, imem_req=0, instr_valid=0, halted=0; all outputs 0. Reset mid-fetch abandons the request; a late imem_ack after release is ignored unless in FETCH.
- States: RESET -> FETCH (first clk after rst deasserts).
- FETCH:
  - imem_req=1, imem_addr=PC, both held stable until ack.
  - On a clk edge with imem_ack=1: IR<=imem_rdata, go EXEC. Min 1 cycle in FETCH (ack in the first FETCH cycle accepted).
  - No timeout; waits indefinitely.
- EXEC:
  - imem_req=0, instr_valid=1, opcode/op_a/op_b driven from IR (registered, stable all cycle).
  - At the edge:
    - if opcode==HALT_OP: go HALT, PC unchanged (HALT priority over jmp_sel).
    - else if jmp_sel=1: PC<=IR[ADDR_W-1:0], go FETCH.
    - else PC<=PC+1 modulo 2^ADDR_W (wraps max->0), go FETCH.
- HALT: halted=1, imem_req=0, instr_valid=0, IR/PC frozen; exit only via rst.
- imem_ack outside FETCH ignored; imem_rdata ignored without ack.
- Throughput: best case 2 cycles/instruction (FETCH with immediate ack + EXEC).
- opcode/op_a/op_b hold last IR value outside EXEC; consumers qualify with instr_valid.
- jmp_sel outside EXEC has no effect.

Test Plan:
- Reset release, memory acks immediately with words 0x041,0x082 at addr 0,1 -> imem_addr 0 then 1; instr_valid pulses with opcode 4'b0001/op_a 0/op_b 1 then 4'b0010/0/2; pc 0->1->2.
- Ack delayed 3 cycles -> imem_req and imem_addr=0 stable for 3 cycles; IR updates only on ack cycle; single instr_valid pulse.
- Word 0x109 (opcode 0100, low bits 1001) with jmp_sel=1 in EXEC -> next imem_addr=9; same word with jmp_sel=0 -> next imem_addr=PC+1.
- PC=15, non-jump instruction -> next fetch addr 0 (wrap).
- Fetch 0x3C0 (HALT) with jmp_sel=1 -> halted=1, imem_req stays 0, pc unchanged for 20 cycles; stray imem_ack pulses ignored.
- Assert rst mid-FETCH (req=1) and in HALT -> outputs 0 immediately (async), next fetch from addr 0 after release.
